// File: rtl/pipe_generator.sv
// Source stage of the pipe-column shift chain: emits one 15-row column per move
// tick. Runs of empty columns alternate with pipe columns, and each pipe has a
// pseudo-random gap. Column generation freezes while game_over is high.
module pipe_generator #(
    parameter int          ROWS      = 15,
    parameter int          TICK_DIV  = 176,
    parameter int          PIPE_W    = 2,
    parameter int          SPACE_W   = 4,
    parameter int          GAP_H     = 4,
    parameter int          MIN_EDGE  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            game_over,
    output logic [ROWS-1:0] pipe_out,
    output logic            move_tick,
    output logic            pipe_spawn,
    output logic [3:0]      gap_row
);

    localparam int RANGE   = ROWS - GAP_H - 2*MIN_EDGE + 1;
    localparam int CNT_MAX = (PIPE_W > SPACE_W) ? PIPE_W : SPACE_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Reject parameter sets that cannot produce a legal pipe column
    if (PIPE_W < 1 || SPACE_W < 1 || GAP_H < 1 || MIN_EDGE < 0) begin : g_chk_widths
        $error("pipe_generator: PIPE_W, SPACE_W, GAP_H must be >= 1 and MIN_EDGE >= 0");
    end
    if (GAP_H + 2*MIN_EDGE > ROWS) begin : g_chk_fit
        $error("pipe_generator: GAP_H + 2*MIN_EDGE must not exceed ROWS");
    end
    if (ROWS - GAP_H - MIN_EDGE > 15 || ROWS > 16) begin : g_chk_rows
        $error("pipe_generator: gap_row must fit in 4 bits");
    end
    if (TICK_DIV < 2) begin : g_chk_tick
        $error("pipe_generator: TICK_DIV must be >= 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_chk_seed
        $error("pipe_generator: LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPACE,
        S_PIPE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_col_cnt, w_col_cnt_nxt;
    logic [ROWS-1:0]  r_pipe_out, w_pipe_out_nxt;
    logic [3:0]       r_gap_row, w_gap_row_nxt;
    logic             r_spawn, w_spawn_nxt;
    logic [15:0]      r_lfsr, w_lfsr_nxt;
    logic [TC_W-1:0]  r_tick_cnt;

    logic             w_tick;
    logic             w_accept;
    logic [15:0]      w_lfsr_step;
    logic [3:0]       w_gap;
    logic [ROWS-1:0]  w_pattern;

    assign w_tick      = (r_tick_cnt == TC_W'(TICK_DIV - 1));
    assign w_accept    = w_tick & ~game_over & (r_state != S_IDLE);
    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_gap       = 4'(MIN_EDGE + (int'(r_lfsr[7:0]) % RANGE));
    assign w_pattern   = ~(ROWS'((1 << GAP_H) - 1) << w_gap);

    // Free-running move-tick divider, unaffected by state or game_over
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TC_W'(1);
        end
    end

    // State, column counter, emitted column, gap and LFSR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_col_cnt  <= '0;
            r_pipe_out <= '0;
            r_gap_row  <= '0;
            r_spawn    <= 1'b0;
            r_lfsr     <= LFSR_SEED;
        end else begin
            r_state    <= w_state_nxt;
            r_col_cnt  <= w_col_cnt_nxt;
            r_pipe_out <= w_pipe_out_nxt;
            r_gap_row  <= w_gap_row_nxt;
            r_spawn    <= w_spawn_nxt;
            r_lfsr     <= w_lfsr_nxt;
        end
    end

    // Next-state logic; SPACE->PIPE emits the first pipe column on the same tick
    always_comb begin
        w_state_nxt    = r_state;
        w_col_cnt_nxt  = r_col_cnt;
        w_pipe_out_nxt = r_pipe_out;
        w_gap_row_nxt  = r_gap_row;
        w_spawn_nxt    = 1'b0;
        w_lfsr_nxt     = r_lfsr;
        case (r_state)
            S_IDLE: begin
                if (!game_over) begin
                    w_lfsr_nxt = w_lfsr_step;
                    if (start) begin
                        w_state_nxt   = S_SPACE;
                        w_col_cnt_nxt = '0;
                    end
                end
            end
            S_SPACE: begin
                if (w_accept) begin
                    w_lfsr_nxt = w_lfsr_step;
                    if (r_col_cnt == CNT_W'(SPACE_W)) begin
                        w_state_nxt    = S_PIPE;
                        w_pipe_out_nxt = w_pattern;
                        w_gap_row_nxt  = w_gap;
                        w_spawn_nxt    = 1'b1;
                        w_col_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_pipe_out_nxt = '0;
                        w_col_cnt_nxt  = r_col_cnt + CNT_W'(1);
                    end
                end
            end
            S_PIPE: begin
                if (w_accept) begin
                    w_lfsr_nxt = w_lfsr_step;
                    if (r_col_cnt == CNT_W'(PIPE_W)) begin
                        w_state_nxt    = S_SPACE;
                        w_pipe_out_nxt = '0;
                        w_col_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_col_cnt_nxt  = r_col_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pipe_out   = r_pipe_out;
    assign move_tick  = w_tick;
    assign pipe_spawn = r_spawn;
    assign gap_row    = r_gap_row;

endmodule
